// File: rtl/cnn_layer2_controller.sv
// Sequencing FSM for the layer-2 CNN datapath: filter load, window load, 16-step MAC, shift, memory commit.
// Define CNN_L2_CTRL_PERF_CNT_EN to add the perf_cycles / perf_stalls counters.
`timescale 1ns/1ps
module cnn_layer2_controller #(
  parameter int unsigned KERNEL_COUNT = 4,
  parameter int unsigned NUM_OUTPUTS  = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    filt_valid,
  output logic                    filt_ready,
  input  logic                    win_valid,
  output logic                    win_ready,
  input  logic                    cout_filter_write_index,
  input  logic                    cout_window_write_index,
  input  logic                    cout_mac_index,
  output logic [KERNEL_COUNT-1:0] filter_wr_en,
  output logic                    write_filter_buff_counter_en,
  output logic                    window_wr_en,
  output logic                    write_window_counter_en,
  output logic                    read_filter_buff_counter_en,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic                    shift_reg_en,
  output logic                    mem_wr_en,
  output logic                    load_w,
  output logic                    done,
  output logic                    busy
`ifdef CNN_L2_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stalls
`endif
);

  localparam int unsigned KW        = (KERNEL_COUNT > 1) ? $clog2(KERNEL_COUNT) : 1;
  localparam int unsigned TOTAL_WIN = 4 * NUM_OUTPUTS;
  localparam int unsigned WCW       = $clog2(TOTAL_WIN + 1);
  localparam logic [KERNEL_COUNT-1:0] K0_SEL = KERNEL_COUNT'(1) << (KERNEL_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_FILT, S_LOAD_WIN, S_MAC, S_SHIFT, S_WRITE, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   kidx, kidx_nxt;
  logic [WCW-1:0]  win_cnt, win_cnt_nxt;
  logic [1:0]      grp, grp_nxt;

  // Next-state and pass-counter logic
  always_comb begin
    state_nxt   = state;
    kidx_nxt    = kidx;
    win_cnt_nxt = win_cnt;
    grp_nxt     = grp;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_LOAD_FILT;
          kidx_nxt    = '0;
          win_cnt_nxt = '0;
          grp_nxt     = '0;
        end
      end
      S_LOAD_FILT: begin
        if (filt_valid && cout_filter_write_index) begin
          if (kidx == KW'(KERNEL_COUNT - 1)) state_nxt = S_LOAD_WIN;
          else                               kidx_nxt  = kidx + KW'(1);
        end
      end
      S_LOAD_WIN: begin
        if (win_valid && cout_window_write_index) state_nxt = S_MAC;
      end
      S_MAC: begin
        if (cout_mac_index) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        win_cnt_nxt = (win_cnt == WCW'(TOTAL_WIN)) ? win_cnt : win_cnt + WCW'(1);
        grp_nxt     = grp + 2'd1;
        state_nxt   = (grp == 2'd3) ? S_WRITE : S_LOAD_WIN;
      end
      S_WRITE: begin
        state_nxt = (win_cnt == WCW'(TOTAL_WIN)) ? S_DONE : S_LOAD_WIN;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; state-only outputs are registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                       <= S_IDLE;
      kidx                        <= '0;
      win_cnt                     <= '0;
      grp                         <= '0;
      filt_ready                  <= 1'b0;
      win_ready                   <= 1'b0;
      mac_en                      <= 1'b0;
      read_filter_buff_counter_en <= 1'b0;
      shift_reg_en                <= 1'b0;
      mac_clr                     <= 1'b0;
      mem_wr_en                   <= 1'b0;
      load_w                      <= 1'b0;
      done                        <= 1'b0;
      busy                        <= 1'b0;
    end else begin
      state                       <= state_nxt;
      kidx                        <= kidx_nxt;
      win_cnt                     <= win_cnt_nxt;
      grp                         <= grp_nxt;
      filt_ready                  <= (state_nxt == S_LOAD_FILT);
      win_ready                   <= (state_nxt == S_LOAD_WIN);
      mac_en                      <= (state_nxt == S_MAC);
      read_filter_buff_counter_en <= (state_nxt == S_MAC);
      shift_reg_en                <= (state_nxt == S_SHIFT);
      mac_clr                     <= (state_nxt == S_SHIFT);
      mem_wr_en                   <= (state_nxt == S_WRITE);
      load_w                      <= (state_nxt == S_WRITE);
      done                        <= (state_nxt == S_DONE);
      busy                        <= (state_nxt != S_IDLE);
    end
  end

  // Handshake-qualified enables: only an accepted transfer advances anything
  assign write_filter_buff_counter_en = filt_ready & filt_valid;
  assign window_wr_en                 = win_ready & win_valid;
  assign write_window_counter_en      = win_ready & win_valid;

  always_comb begin
    filter_wr_en = '0;
    if (filt_ready && filt_valid) filter_wr_en = K0_SEL >> kidx;
  end

`ifdef CNN_L2_CTRL_PERF_CNT_EN
  // Busy-cycle and upstream-stall counters, restarted when a pass is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        perf_cycles <= '0;
        perf_stalls <= '0;
      end
    end else begin
      perf_cycles <= perf_cycles + 32'(1);
      if ((state == S_LOAD_FILT && !filt_valid) || (state == S_LOAD_WIN && !win_valid))
        perf_stalls <= perf_stalls + 32'(1);
    end
  end
`endif

endmodule
